// File: rtl/cdc_4phase_tx_feeder.sv
// Source-domain FIFO that turns a valid/ready stream into the single-cycle
// valid/busy handshake of the 4-phase CDC, one word per CDC round trip.
module cdc_4phase_tx_feeder #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DATA_W-1:0]        s_data,
  input  logic                     cdc_busy,
  output logic                     cdc_valid,
  output logic [DATA_W-1:0]        cdc_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         sent_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]      PTR_ONE = (AW+1)'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic              r_cdc_valid;
  logic [DATA_W-1:0] r_cdc_data;
  logic [CNT_W-1:0]  r_sent_cnt;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic [DATA_W-1:0] w_rd_data;

  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_push    = s_valid & ~w_full;
  // The CDC raises busy only the cycle after it samples valid, so the issue
  // cycle itself must also block the next pop.
  assign w_pop     = ~w_empty & ~cdc_busy & ~r_cdc_valid;
  assign w_rd_data = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= s_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_cdc_valid <= 1'b0;
      r_cdc_data  <= '0;
      r_sent_cnt  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr   <= r_rd_ptr + PTR_ONE;
        r_cdc_data <= w_rd_data;
        r_sent_cnt <= r_sent_cnt + CNT_ONE;
      end
      r_cdc_valid <= w_pop;
    end
  end

  assign s_ready   = ~w_full;
  assign cdc_valid = r_cdc_valid;
  assign cdc_data  = r_cdc_data;
  assign level     = r_wr_ptr - r_rd_ptr;
  assign sent_cnt  = r_sent_cnt;

endmodule

// File: tb/tb_cdc_4phase_tx_feeder.sv
// Scoreboard bench for the CDC feeder: queued expected words, a busy model of
// the downstream CDC, and per-scenario inline checks.
module tb_cdc_4phase_tx_feeder;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 4;

  logic              i_clk;
  logic              i_rstn;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              cdc_busy;
  logic              cdc_valid;
  logic [DATA_W-1:0] cdc_data;
  logic [2:0]        level;
  logic [CNT_W-1:0]  sent_cnt;

  int errors = 0;
  int checks = 0;
  int rx_count = 0;
  logic [DATA_W-1:0] q[$];

  logic force_busy;
  logic model_en;
  int   busy_cnt;
  logic last_valid;

  cdc_4phase_tx_feeder #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .cdc_busy(cdc_busy), .cdc_valid(cdc_valid),
    .cdc_data(cdc_data), .level(level), .sent_cnt(sent_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // CDC busy model: high for 6 cycles starting the cycle after each valid.
  always @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) busy_cnt <= 0;
    else if (model_en && cdc_valid) busy_cnt <= 6;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign cdc_busy = force_busy | (busy_cnt != 0);

  // Output monitor: order, no issue while busy, no back-to-back valids.
  always @(negedge i_clk) begin
    logic [DATA_W-1:0] exp_d;
    if (!i_rstn) begin
      last_valid = 1'b0;
    end else begin
      if (cdc_valid) begin
        rx_count++;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_issue: cdc_data=%02h issued with nothing expected", cdc_data);
        end else begin
          exp_d = q.pop_front();
          if (cdc_data !== exp_d) begin
            errors++;
            $display("FAIL issue_order: cdc_data=%02h expected %02h", cdc_data, exp_d);
          end
        end
        checks++;
        if (cdc_busy !== 1'b0) begin
          errors++;
          $display("FAIL issue_while_busy: cdc_busy=%b expected 0", cdc_busy);
        end
        checks++;
        if (last_valid !== 1'b0) begin
          errors++;
          $display("FAIL back_to_back_valid: previous cdc_valid=%b expected 0", last_valid);
        end
      end
      last_valid = cdc_valid;
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic apply_reset();
    i_rstn     = 1'b0;
    s_valid    = 1'b0;
    s_data     = '0;
    force_busy = 1'b0;
    model_en   = 1'b0;
    q.delete();
    repeat (3) tick();
    i_rstn = 1'b1;
    tick();
  endtask

  // Offer one word for one cycle; acc reports whether it was taken.
  task automatic push_word(input logic [DATA_W-1:0] d, output bit acc);
    s_valid = 1'b1;
    s_data  = d;
    @(negedge i_clk);
    acc = s_ready;
    tick();
    s_valid = 1'b0;
    if (acc) q.push_back(d);
  endtask

  task automatic wait_drain(input int max_cycles);
    bit done = 1'b0;
    for (int i = 0; i < max_cycles && !done; i++) begin
      tick();
      if (q.size() == 0 && level == 0 && !cdc_valid && !cdc_busy) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain_timeout: pending=%0d level=%0d expected 0 within %0d cycles",
               q.size(), level, max_cycles);
    end
  endtask

  task automatic test_reset();
    i_rstn = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    force_busy = 1'b0;
    model_en = 1'b0;
    #1;
    checks++;
    if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready_during: got %b expected 1", s_ready); end
    apply_reset();
    checks++;
    if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %b expected 1", s_ready); end
    checks++;
    if (level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
    checks++;
    if (cdc_valid !== 1'b0) begin errors++; $display("FAIL reset_cdc_valid: got %b expected 0", cdc_valid); end
    checks++;
    if (cdc_data !== 8'h00) begin errors++; $display("FAIL reset_cdc_data: got %02h expected 00", cdc_data); end
    checks++;
    if (sent_cnt !== 4'd0) begin errors++; $display("FAIL reset_sent_cnt: got %0d expected 0", sent_cnt); end
  endtask

  task automatic test_single_latency();
    s_valid = 1'b1;
    s_data  = 8'hA5;
    q.push_back(8'hA5);
    tick();
    s_valid = 1'b0;
    checks++;
    if (cdc_valid !== 1'b0) begin errors++; $display("FAIL latency_early: cdc_valid=%b expected 0 one cycle after push", cdc_valid); end
    checks++;
    if (level !== 3'd1) begin errors++; $display("FAIL latency_level: got %0d expected 1", level); end
    tick();
    checks++;
    if (cdc_valid !== 1'b1) begin errors++; $display("FAIL latency_valid: cdc_valid=%b expected 1 two cycles after push", cdc_valid); end
    checks++;
    if (cdc_data !== 8'hA5) begin errors++; $display("FAIL latency_data: got %02h expected a5", cdc_data); end
    checks++;
    if (sent_cnt !== 4'd1) begin errors++; $display("FAIL latency_sent_cnt: got %0d expected 1", sent_cnt); end
    tick();
    checks++;
    if (cdc_valid !== 1'b0) begin errors++; $display("FAIL latency_pulse_width: cdc_valid=%b expected 0", cdc_valid); end
    checks++;
    if (cdc_data !== 8'hA5) begin errors++; $display("FAIL latency_data_hold: got %02h expected a5", cdc_data); end
    wait_drain(20);
  endtask

  task automatic test_full();
    logic [DATA_W-1:0] words [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    bit acc;
    force_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_word(words[i], acc);
      checks++;
      if (acc !== 1'b1) begin errors++; $display("FAIL full_accept_%0d: s_ready=%b expected 1", i, acc); end
    end
    checks++;
    if (level !== 3'd4) begin errors++; $display("FAIL full_level: got %0d expected 4", level); end
    checks++;
    if (s_ready !== 1'b0) begin errors++; $display("FAIL full_s_ready: got %b expected 0", s_ready); end
    push_word(8'h55, acc);
    checks++;
    if (acc !== 1'b0) begin errors++; $display("FAIL full_fifth_word: accepted=%b expected 0", acc); end
    checks++;
    if (level !== 3'd4) begin errors++; $display("FAIL full_level_hold: got %0d expected 4", level); end
    force_busy = 1'b0;
    wait_drain(60);
  endtask

  task automatic test_stream();
    bit acc;
    int sent = 0;
    int tries = 0;
    logic [DATA_W-1:0] d;
    rx_count = 0;
    model_en = 1'b1;
    d = 8'($urandom);
    while (sent < 20 && tries < 2000) begin
      push_word(d, acc);
      tries++;
      if (acc) begin
        sent++;
        d = 8'($urandom);
      end
    end
    checks++;
    if (sent != 20) begin errors++; $display("FAIL stream_accept: accepted %0d words expected 20", sent); end
    wait_drain(400);
    checks++;
    if (rx_count != 20) begin errors++; $display("FAIL stream_count: received %0d words expected 20", rx_count); end
    model_en = 1'b0;
    wait_drain(20);
  endtask

  task automatic test_push_pop_same_cycle();
    bit acc;
    force_busy = 1'b1;
    push_word(8'hC1, acc);
    push_word(8'hC2, acc);
    checks++;
    if (level !== 3'd2) begin errors++; $display("FAIL pp_level_before: got %0d expected 2", level); end
    force_busy = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'hC3;
    q.push_back(8'hC3);
    tick();
    s_valid = 1'b0;
    checks++;
    if (level !== 3'd2) begin errors++; $display("FAIL pp_level_after: got %0d expected 2", level); end
    checks++;
    if (cdc_valid !== 1'b1) begin errors++; $display("FAIL pp_issue: cdc_valid=%b expected 1", cdc_valid); end
    wait_drain(40);
  endtask

  task automatic test_reset_mid_op();
    bit acc;
    force_busy = 1'b1;
    for (int i = 0; i < 4; i++) push_word(8'hD0 + 8'(i), acc);
    force_busy = 1'b0;
    tick();
    checks++;
    if (cdc_valid !== 1'b1 || level !== 3'd3) begin
      errors++;
      $display("FAIL rst_setup: cdc_valid=%b level=%0d expected 1 and 3", cdc_valid, level);
    end
    i_rstn = 1'b0;
    q.delete();
    #1;
    checks++;
    if (cdc_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid: got %b expected 0", cdc_valid); end
    checks++;
    if (level !== 3'd0) begin errors++; $display("FAIL rst_async_level: got %0d expected 0", level); end
    checks++;
    if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_async_s_ready: got %b expected 1", s_ready); end
    repeat (2) tick();
    i_rstn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (cdc_valid !== 1'b0) begin errors++; $display("FAIL rst_stale_issue: cycle %0d cdc_valid=%b expected 0", i, cdc_valid); end
    end
    checks++;
    if (sent_cnt !== 4'd0) begin errors++; $display("FAIL rst_sent_cnt: got %0d expected 0", sent_cnt); end
  endtask

  task automatic test_counter_wrap();
    bit acc;
    int sent = 0;
    int tries = 0;
    apply_reset();
    rx_count = 0;
    model_en = 1'b1;
    while (sent < 17 && tries < 2000) begin
      push_word(8'h40 + 8'(sent), acc);
      tries++;
      if (acc) sent++;
    end
    wait_drain(400);
    checks++;
    if (rx_count != 17) begin errors++; $display("FAIL wrap_count: received %0d words expected 17", rx_count); end
    checks++;
    if (sent_cnt !== 4'd1) begin errors++; $display("FAIL wrap_sent_cnt: got %0d expected 1", sent_cnt); end
    model_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_latency();
    test_full();
    test_stream();
    test_push_pop_same_cycle();
    test_reset_mid_op();
    test_counter_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
